// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-transfer Wishbone classic master with timeout
//
// Purpose: turns one client request (req_i with we_i/addr_i/wdata_i) into one
// Wishbone classic cycle. The cycle ends on ack, err or timeout. A one-cycle
// RECOVER gap always follows before the next request can be accepted.
//
// Ports:
//   wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//   req_i, we_i, addr_i, wdata_i   client request; req_i is sampled in IDLE only
//   busy_o                         1 while not IDLE
//   done_o, err_o                  one-cycle completion / failure pulses
//   rdata_o                        byte from the last successful read
//   wbm_cyc_o, wbm_stb_o, wbm_we_o master controls
//   wbm_sel_o, wbm_adr_o, wbm_dat_o lane select, address, write data
//   wbm_ack_i, wbm_err_i, wbm_dat_i slave responses
module wb_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

  // Counter value seen on the TIMEOUT-th BUS edge: the counter is cleared on
  // entry to BUS and advances once per edge that passes with no response.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        in_bus;

  // Only the low byte lane is ever selected, so the upper read bytes are dropped.
  logic        unused_dat_hi;
  assign unused_dat_hi = ^wbm_dat_i[31:8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wdat_q  <= 8'h0;
      cnt_q   <= 8'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = addr_i;
          wdat_d  = wdata_i;
          cnt_d   = 8'h0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // err wins over a simultaneous ack; a response on the last allowed
        // edge still counts as a response rather than a timeout.
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else if (wbm_ack_i) begin
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = wbm_dat_i[7:0];
          end
          state_d = S_RECOVER;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RECOVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state flop so an asynchronous reset
  // drops them without waiting for a clock edge.
  assign in_bus    = (state_q == S_BUS);
  assign wbm_cyc_o = in_bus;
  assign wbm_stb_o = in_bus;
  assign wbm_sel_o = in_bus ? 4'b0001 : 4'b0000;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = {24'h0, wdat_q};

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; max BUS-state cycles waiting for ack/err before abort (legal 2..255).
REQ-002 SHALL have port wb_clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port wb_rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  input  1  client request strobe, sampled in IDLE only.
REQ-005 SHALL have port we_i  input  1  client direction, 1=write 0=read.
REQ-006 SHALL have port addr_i  input  32  client byte address.
REQ-007 SHALL have port wdata_i  input  8  client write data.
REQ-008 SHALL have ports busy_o, done_o, err_o  output  1 each  not-IDLE / completion pulse / failure pulse.
REQ-009 SHALL have port rdata_o  output  8  last successful read data.
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-011 SHALL have ports wbm_sel_o 4, wbm_adr_o 32, wbm_dat_o 32  output  master select/address/write data.
REQ-012 SHALL have ports wbm_ack_i 1, wbm_err_i 1, wbm_dat_i 32  input  slave responses.

Function
REQ-013 SHALL implement FSM states IDLE, BUS, RECOVER.
REQ-014 IDLE: req_i=1 at edge SHALL latch we_i, addr_i, wdata_i, clear timeout counter, enter BUS; cyc/stb high from next cycle.
REQ-015 BUS: wbm_cyc_o=wbm_stb_o=1; wbm_we_o, wbm_adr_o = latched values; wbm_dat_o = {24'h0, latched wdata}; wbm_sel_o = 4'b0001.
REQ-016 wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o SHALL hold stable throughout BUS.
REQ-017 BUS, wbm_ack_i=1 at edge: read SHALL load rdata_o <= wbm_dat_i[7:0]; done_o pulses 1 cycle; cyc/stb drop; enter RECOVER.
REQ-018 BUS, wbm_err_i=1 at edge (ack=0): err_o pulses 1 cycle, rdata_o unchanged, cyc/stb drop, enter RECOVER.
REQ-019 ack and err both 1 in same edge: SHALL be treated as err (REQ-018).
REQ-020 8-bit counter SHALL count edges in BUS; on the TIMEOUT-th edge with no ack/err: err_o pulse, abort, enter RECOVER; no wrap-around.
REQ-021 Single-cycle ack (ack on first BUS edge) SHALL complete normally: BUS lasts exactly 1 cycle.
REQ-022 RECOVER: cyc/stb low exactly 1 cycle, req_i ignored, then IDLE; min spacing between bus cycles = 1 idle cycle.
REQ-023 req_i in BUS or RECOVER SHALL be ignored, not queued.
REQ-024 busy_o SHALL be 1 in BUS and RECOVER, 0 in IDLE.
REQ-025 Latency: req edge -> stb high 1 cycle; ack edge -> done_o high 1 cycle; request-to-request throughput 3 cycles with zero-wait slave.
REQ-026 done_o and err_o SHALL be registered, never both 1.
REQ-027 wbm_ack_i/wbm_err_i outside BUS SHALL be ignored.

Reset
REQ-028 wb_rst_ni=0 SHALL immediately force IDLE, cyc/stb/we=0, sel=0, adr=0, dat=0, done/err/busy=0, rdata_o=0, counter=0.
REQ-029 Reset assertion mid-BUS SHALL drop cyc/stb asynchronously; no done/err pulse for aborted cycle.
REQ-030 After deassertion, first edge SHALL sample req_i normally.

Verification
REQ-031 Write: req, we=1, addr=0x3000_0105, wdata=0xA5, ack 1 cycle later -> adr=0x3000_0105, dat=0x0000_00A5, sel=0001, done pulse, rdata_o unchanged.
REQ-032 Read: addr=0x3000_0010, slave returns 0x1234_5678 with 3 wait cycles -> stb held 4 cycles, rdata_o=0x78, done pulse.
REQ-033 Timeout: TIMEOUT=8, slave never acks -> stb high exactly 8 cycles, err_o pulse, rdata_o unchanged, busy_o low 2 cycles after.
REQ-034 Slave err with ack same cycle -> err_o=1, done_o=0.
REQ-035 req_i held high continuously, zero-wait slave -> stb pulses every 3rd cycle, each followed by RECOVER.
REQ-036 wb_rst_ni low mid-BUS, no clock edge -> cyc/stb 0 immediately, all outputs at reset values, no pulses.
